// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the hazard/forwarding scoreboard.
// Shadow entries are sized for the widest legal configuration so one type serves every instance.
package hazard_pkg;

    localparam int REG_W_MAX = 8;
    localparam int SEL_W_MAX = 3;

    localparam int FWD_RF = 0;
    localparam int EX     = 0;
    localparam int MEM    = 1;

    typedef struct packed {
        logic                 valid;
        logic                 regwrite;
        logic [REG_W_MAX-1:0] rd;
        logic [SEL_W_MAX-1:0] ready_stage;
    } shadow_entry_t;

    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID/EX-side request signals and hazard/forwarding responses of hazard_scoreboard.
interface hazard_scoreboard_if #(
    parameter int DEPTH  = 3,
    parameter int REG_W  = 5,
    parameter int PERF_W = 32
);
    import hazard_pkg::*;

    localparam int SEL_W = clog2_min1(DEPTH);

    logic              id_valid;
    logic [REG_W-1:0]  id_rs1;
    logic [REG_W-1:0]  id_rs2;
    logic [REG_W-1:0]  id_rd;
    logic              id_regwrite;
    logic [SEL_W-1:0]  id_ready_stage;
    logic [REG_W-1:0]  ex_rs1;
    logic [REG_W-1:0]  ex_rs2;
    logic              branch_taken;
    logic              mem_stall;
    logic              stall;
    logic              flush;
    logic [SEL_W-1:0]  fwd_sel_a;
    logic [SEL_W-1:0]  fwd_sel_b;
    logic [PERF_W-1:0] stall_cycles;
    logic [PERF_W-1:0] flush_cycles;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_ready_stage,
        output ex_rs1, ex_rs2, branch_taken, mem_stall,
        input  stall, flush, fwd_sel_a, fwd_sel_b, stall_cycles, flush_cycles
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_ready_stage,
        input  ex_rs1, ex_rs2, branch_taken, mem_stall,
        output stall, flush, fwd_sel_a, fwd_sel_b, stall_cycles, flush_cycles
    );

endinterface

// File: rtl/hazard_scoreboard_match.sv
// Finds the youngest producer of one source register within stages LO..HI of the shadow pipe.
// ready_o means the found result exists early enough: ready_stage + 1 <= index + READY_OFS.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int DEPTH     = 3,
    parameter int REG_W     = 5,
    parameter int SEL_W     = 2,
    parameter int LO        = 0,
    parameter int HI        = 1,
    parameter int READY_OFS = 0
) (
    input  shadow_entry_t    entries_i [DEPTH],
    input  logic [REG_W-1:0] src_i,
    output logic [SEL_W-1:0] idx_o,
    output logic             hit_o,
    output logic             ready_o
);

    always_comb begin
        // NOTE: every output gets a default before the search so no path infers a latch.
        idx_o   = '0;
        hit_o   = 1'b0;
        ready_o = 1'b0;
        // Oldest first, so a younger match overwrites an older one.
        for (int k = HI; k >= LO; k--) begin
            if (entries_i[k].valid && entries_i[k].regwrite &&
                entries_i[k].rd != '0 && entries_i[k].rd == REG_W_MAX'(src_i)) begin
                idx_o   = SEL_W'(k);
                hit_o   = 1'b1;
                ready_o = (int'(entries_i[k].ready_stage) + 1) <= (k + READY_OFS);
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding unit between ID and EX: shadow pipe of in-flight destinations,
// ID stall, multi-cycle branch flush, EX forwarding selects and saturating event counters.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int DEPTH     = 3,
    parameter int REG_W     = 5,
    parameter int FLUSH_LEN = 1,
    parameter int PERF_W    = 32
) (
    input logic               clk,
    input logic               rst,
    hazard_scoreboard_if.slave bus
);

    localparam int SEL_W = clog2_min1(DEPTH);
    localparam int CNT_W = clog2_min1(FLUSH_LEN);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_LEN - 1);

    shadow_entry_t     pipe_q [DEPTH];
    shadow_entry_t     pipe_d [DEPTH];
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [PERF_W-1:0] flush_cycles_q, flush_cycles_d;

    logic [REG_W-1:0]  ex_src [2];
    logic [REG_W-1:0]  id_src [2];
    logic [SEL_W-1:0]  ex_idx [2];
    logic              ex_hit [2];
    logic              ex_rdy [2];
    logic [SEL_W-1:0]  id_idx_unused [2];
    logic              id_hit [2];
    logic              id_rdy [2];

    logic flush_raw, hazard, stall_int, flush_int;

    assign ex_src[0] = bus.ex_rs1;
    assign ex_src[1] = bus.ex_rs2;
    assign id_src[0] = bus.id_rs1;
    assign id_src[1] = bus.id_rs2;

    // Forwarding looks at MEM..WB; the stall check skips WB because the register file is write-first.
    for (genvar i = 0; i < 2; i++) begin : g_src
        hazard_match #(
            .DEPTH(DEPTH), .REG_W(REG_W), .SEL_W(SEL_W),
            .LO(MEM), .HI(DEPTH - 1), .READY_OFS(0)
        ) u_fwd (
            .entries_i(pipe_q), .src_i(ex_src[i]),
            .idx_o(ex_idx[i]), .hit_o(ex_hit[i]), .ready_o(ex_rdy[i])
        );

        hazard_match #(
            .DEPTH(DEPTH), .REG_W(REG_W), .SEL_W(SEL_W),
            .LO(EX), .HI(DEPTH - 2), .READY_OFS(1)
        ) u_stall (
            .entries_i(pipe_q), .src_i(id_src[i]),
            .idx_o(id_idx_unused[i]), .hit_o(id_hit[i]), .ready_o(id_rdy[i])
        );
    end

    always_comb begin
        flush_raw = bus.branch_taken || (flush_cnt_q != '0);
        hazard    = bus.id_valid && ((id_hit[0] && !id_rdy[0]) || (id_hit[1] && !id_rdy[1]));
        flush_int = !rst && !bus.mem_stall && flush_raw;
        stall_int = !rst && !bus.mem_stall && !flush_raw && hazard;
    end

    assign bus.stall        = stall_int;
    assign bus.flush        = flush_int;
    assign bus.fwd_sel_a    = (!rst && ex_hit[0] && ex_rdy[0]) ? ex_idx[0] : SEL_W'(FWD_RF);
    assign bus.fwd_sel_b    = (!rst && ex_hit[1] && ex_rdy[1]) ? ex_idx[1] : SEL_W'(FWD_RF);
    assign bus.stall_cycles = stall_cycles_q;
    assign bus.flush_cycles = flush_cycles_q;

    always_comb begin
        pipe_d         = pipe_q;
        flush_cnt_d    = flush_cnt_q;
        stall_cycles_d = stall_cycles_q;
        flush_cycles_d = flush_cycles_q;

        if (!bus.mem_stall) begin
            for (int k = DEPTH - 1; k > EX; k--) begin
                pipe_d[k] = pipe_q[k-1];
            end
            pipe_d[EX] = '0;
            if (bus.id_valid && !stall_int && !flush_int) begin
                pipe_d[EX] = '{valid:       1'b1,
                               regwrite:    bus.id_regwrite,
                               rd:          REG_W_MAX'(bus.id_rd),
                               ready_stage: SEL_W_MAX'(bus.id_ready_stage)};
            end

            // A taken branch seen while the window is open is on the wrong path and is ignored.
            if (flush_cnt_q != '0) begin
                flush_cnt_d = flush_cnt_q - CNT_W'(1);
            end else if (bus.branch_taken) begin
                flush_cnt_d = FLUSH_LOAD;
            end

            if (stall_int && stall_cycles_q != '1) begin
                stall_cycles_d = stall_cycles_q + PERF_W'(1);
            end
            if (flush_int && flush_cycles_q != '1) begin
                flush_cycles_d = flush_cycles_q + PERF_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the shadow pipe is a few flops, not a RAM; its valid bits must start clear.
            for (int k = 0; k < DEPTH; k++) begin
                pipe_q[k] <= '0;
            end
            flush_cnt_q    <= '0;
            stall_cycles_q <= '0;
            flush_cycles_q <= '0;
        end else begin
            // NOTE: state uses <= so every register samples pre-edge values.
            pipe_q         <= pipe_d;
            flush_cnt_q    <= flush_cnt_d;
            stall_cycles_q <= stall_cycles_d;
            flush_cycles_q <= flush_cycles_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two configurations driven by directed scenarios and random
// traffic, checked every cycle against a behavioural model of the scoreboard rules.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int REG_W = 5;
    localparam int DA = 3, FA = 1, PA = 32;
    localparam int DB = 5, FB = 2, PB = 4;
    localparam int SA_W = clog2_min1(DA);
    localparam int SB_W = clog2_min1(DB);
    localparam int A = 0, B = 1;

    typedef struct packed {
        logic       id_valid;
        logic [4:0] id_rs1;
        logic [4:0] id_rs2;
        logic [4:0] id_rd;
        logic       id_regwrite;
        logic [2:0] id_ready;
        logic [4:0] ex_rs1;
        logic [4:0] ex_rs2;
        logic       branch_taken;
        logic       mem_stall;
    } stim_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    stim_t st [2];
    int    n_checks = 0;
    int    n_fail   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.DEPTH(DA), .REG_W(REG_W), .PERF_W(PA)) bus_a ();
    hazard_scoreboard_if #(.DEPTH(DB), .REG_W(REG_W), .PERF_W(PB)) bus_b ();

    hazard_scoreboard #(.DEPTH(DA), .REG_W(REG_W), .FLUSH_LEN(FA), .PERF_W(PA))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    hazard_scoreboard #(.DEPTH(DB), .REG_W(REG_W), .FLUSH_LEN(FB), .PERF_W(PB))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    assign bus_a.id_valid       = st[A].id_valid;
    assign bus_a.id_rs1         = st[A].id_rs1;
    assign bus_a.id_rs2         = st[A].id_rs2;
    assign bus_a.id_rd          = st[A].id_rd;
    assign bus_a.id_regwrite    = st[A].id_regwrite;
    assign bus_a.id_ready_stage = st[A].id_ready[SA_W-1:0];
    assign bus_a.ex_rs1         = st[A].ex_rs1;
    assign bus_a.ex_rs2         = st[A].ex_rs2;
    assign bus_a.branch_taken   = st[A].branch_taken;
    assign bus_a.mem_stall      = st[A].mem_stall;

    assign bus_b.id_valid       = st[B].id_valid;
    assign bus_b.id_rs1         = st[B].id_rs1;
    assign bus_b.id_rs2         = st[B].id_rs2;
    assign bus_b.id_rd          = st[B].id_rd;
    assign bus_b.id_regwrite    = st[B].id_regwrite;
    assign bus_b.id_ready_stage = st[B].id_ready[SB_W-1:0];
    assign bus_b.ex_rs1         = st[B].ex_rs1;
    assign bus_b.ex_rs2         = st[B].ex_rs2;
    assign bus_b.branch_taken   = st[B].branch_taken;
    assign bus_b.mem_stall      = st[B].mem_stall;

    int obs_stall [2], obs_flush [2], obs_fa [2], obs_fb [2], obs_sc [2], obs_fc [2];
    assign obs_stall[A] = int'(bus_a.stall);
    assign obs_flush[A] = int'(bus_a.flush);
    assign obs_fa[A]    = int'(bus_a.fwd_sel_a);
    assign obs_fb[A]    = int'(bus_a.fwd_sel_b);
    assign obs_sc[A]    = int'(bus_a.stall_cycles);
    assign obs_fc[A]    = int'(bus_a.flush_cycles);
    assign obs_stall[B] = int'(bus_b.stall);
    assign obs_flush[B] = int'(bus_b.flush);
    assign obs_fa[B]    = int'(bus_b.fwd_sel_a);
    assign obs_fb[B]    = int'(bus_b.fwd_sel_b);
    assign obs_sc[B]    = int'(bus_b.stall_cycles);
    assign obs_fc[B]    = int'(bus_b.flush_cycles);

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit mv [2][8];
    bit mw [2][8];
    int mrd [2][8];
    int mrs [2][8];
    int mfc [2];
    int msc [2];
    int mflc [2];

    function automatic int depth(int m);  return (m == A) ? DA : DB; endfunction
    function automatic int flen(int m);   return (m == A) ? FA : FB; endfunction
    // All-ones in each counter's width, viewed as an int.
    function automatic int pmax(int m);   return (m == A) ? -1 : (1 << PB) - 1; endfunction

    function automatic bit is_prod(int m, int k);
        return mv[m][k] && mw[m][k] && mrd[m][k] != 0;
    endfunction

    function automatic int fwd_model(int m, int src);
        if (src == 0) return 0;
        for (int k = 1; k < depth(m); k++)
            if (is_prod(m, k) && mrd[m][k] == src) return (mrs[m][k] <= k - 1) ? k : 0;
        return 0;
    endfunction

    function automatic bit hazard_model(int m, int src);
        if (src == 0) return 1'b0;
        for (int j = 0; j <= depth(m) - 2; j++)
            if (is_prod(m, j) && mrd[m][j] == src) return mrs[m][j] > j;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            string tag;
            bit    ef, es;
            int    fa, fb;
            tag = (m == A) ? "a" : "b";
            ef  = !rst && !st[m].mem_stall && (st[m].branch_taken || mfc[m] != 0);
            es  = !rst && !st[m].mem_stall && !ef && st[m].id_valid &&
                  (hazard_model(m, int'(st[m].id_rs1)) || hazard_model(m, int'(st[m].id_rs2)));
            fa  = rst ? 0 : fwd_model(m, int'(st[m].ex_rs1));
            fb  = rst ? 0 : fwd_model(m, int'(st[m].ex_rs2));
            check({"stall_", tag}, obs_stall[m], int'(es));
            check({"flush_", tag}, obs_flush[m], int'(ef));
            check({"fwd_sel_a_", tag}, obs_fa[m], fa);
            check({"fwd_sel_b_", tag}, obs_fb[m], fb);
            check({"stall_cycles_", tag}, obs_sc[m], msc[m]);
            check({"flush_cycles_", tag}, obs_fc[m], mflc[m]);

            if (rst) begin
                for (int k = 0; k < 8; k++) mv[m][k] = 1'b0;
                mfc[m] = 0; msc[m] = 0; mflc[m] = 0;
            end else if (!st[m].mem_stall) begin
                for (int k = depth(m) - 1; k > 0; k--) begin
                    mv[m][k] = mv[m][k-1]; mw[m][k] = mw[m][k-1];
                    mrd[m][k] = mrd[m][k-1]; mrs[m][k] = mrs[m][k-1];
                end
                mv[m][0]  = st[m].id_valid && !es && !ef;
                mw[m][0]  = st[m].id_regwrite;
                mrd[m][0] = int'(st[m].id_rd);
                mrs[m][0] = int'(st[m].id_ready);
                if (mfc[m] != 0) mfc[m]--;
                else if (st[m].branch_taken) mfc[m] = flen(m) - 1;
                if (es && msc[m] != pmax(m)) msc[m]++;
                if (ef && mflc[m] != pmax(m)) mflc[m]++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t instr(int rs1, int rs2, int rd, int ready);
        stim_t s;
        s = '0;
        s.id_valid    = 1'b1;
        s.id_rs1      = 5'(rs1);
        s.id_rs2      = 5'(rs2);
        s.id_rd       = 5'(rd);
        s.id_regwrite = 1'b1;
        s.id_ready    = 3'(ready);
        return s;
    endfunction

    function automatic stim_t with_ex(stim_t s, int r1, int r2);
        stim_t t;
        t = s;
        t.ex_rs1 = 5'(r1);
        t.ex_rs2 = 5'(r2);
        return t;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        st[A] = idle();
        st[B] = idle();
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        st[A] = idle();
        st[B] = idle();
        tick(2);
        rst = 1'b0;

        // ALU chain: add x5 then sub x7,x5,x1
        st[A] = instr(1, 2, 5, 0); tick();
        st[A] = instr(5, 1, 7, 0); settle();
        check("alu_stall", obs_stall[A], 0);
        tick();
        st[A] = with_ex(idle(), 5, 1); settle();
        check("alu_fwd_a", obs_fa[A], 1);
        check("alu_fwd_b", obs_fb[A], 0);

        // Load-use: lw x6 then add x8,x2,x6
        do_reset();
        st[A] = instr(2, 0, 6, 1); tick();
        st[A] = instr(2, 6, 8, 0); settle();
        check("lu_stall", obs_stall[A], 1);
        tick(); settle();
        check("lu_stall_once", obs_stall[A], 0);
        check("lu_stall_cycles", obs_sc[A], 1);
        tick();
        st[A] = with_ex(idle(), 2, 6); settle();
        check("lu_fwd_b", obs_fb[A], 2);
        check("lu_fwd_a", obs_fa[A], 0);

        // Producer of x0 never hazards nor forwards
        do_reset();
        st[A] = instr(0, 0, 0, 1); tick();
        st[A] = instr(0, 0, 4, 0); settle();
        check("x0_stall", obs_stall[A], 0);
        tick(2);
        st[A] = with_ex(idle(), 0, 0); settle();
        check("x0_fwd", obs_fa[A], 0);

        // Two producers of x9 at stages 1 and 2: youngest wins
        do_reset();
        st[A] = instr(0, 0, 9, 0); tick();
        st[A] = instr(0, 0, 9, 0); tick();
        st[A] = idle(); tick();
        st[A] = with_ex(idle(), 9, 0); settle();
        check("alias_fwd", obs_fa[A], 1);

        // Branch on top of a load-use hazard with a two-cycle flush window
        do_reset();
        st[B] = instr(0, 0, 6, 1); tick();
        st[B] = instr(0, 6, 10, 0);
        st[B].branch_taken = 1'b1; settle();
        check("fl_flush_1", obs_flush[B], 1);
        check("fl_stall_1", obs_stall[B], 0);
        tick();
        st[B].branch_taken = 1'b0; settle();
        check("fl_flush_2", obs_flush[B], 1);
        check("fl_stall_2", obs_stall[B], 0);
        tick();
        st[B] = with_ex(st[B], 10, 6); settle();
        check("fl_flush_end", obs_flush[B], 0);
        check("fl_cycles", obs_fc[B], 2);
        check("fl_bubble_fwd", obs_fa[B], 0);
        check("fl_load_fwd", obs_fb[B], 2);

        // Freeze during a load-use, then exactly one stall after release
        do_reset();
        st[A] = instr(0, 0, 6, 1); tick();
        st[A] = instr(0, 6, 8, 0);
        st[A].mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("frz_stall", obs_stall[A], 0);
            tick();
        end
        st[A].mem_stall = 1'b0; settle();
        check("frz_release_stall", obs_stall[A], 1);
        tick(); settle();
        check("frz_after", obs_stall[A], 0);
        check("frz_cycles", obs_sc[A], 1);

        // Reset in the middle of a flush window
        do_reset();
        st[B].branch_taken = 1'b1; settle();
        check("rf_flush_br", obs_flush[B], 1);
        tick();
        st[B].branch_taken = 1'b0; settle();
        check("rf_flush_cnt", obs_flush[B], 1);
        rst = 1'b1; tick();
        rst = 1'b0; settle();
        check("rf_flush_after", obs_flush[B], 0);
        check("rf_cycles_after", obs_fc[B], 0);

        // DEPTH 5, ready stage 3: three stalls then forward from stage 4
        do_reset();
        st[B] = instr(0, 0, 11, 3); tick();
        st[B] = instr(11, 0, 12, 0);
        for (int i = 0; i < 3; i++) begin
            settle();
            check("ds_stall", obs_stall[B], 1);
            tick();
        end
        settle();
        check("ds_stall_end", obs_stall[B], 0);
        tick();
        st[B] = with_ex(idle(), 11, 0); settle();
        check("ds_fwd", obs_fa[B], 4);
        check("ds_cycles", obs_sc[B], 3);

        // 18 stall cycles into a 4-bit counter saturate at 15
        do_reset();
        repeat (6) begin
            st[B] = instr(0, 0, 11, 3); tick();
            st[B] = instr(11, 0, 0, 0); tick(4);
        end
        st[B] = idle(); settle();
        check("sat_stall_cycles", obs_sc[B], 15);

        // Random traffic; the per-cycle model comparison does the checking
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            for (int m = 0; m < 2; m++) begin
                stim_t s;
                s.id_valid     = ($urandom_range(0, 3) != 0);
                s.id_rs1       = 5'($urandom_range(0, 7));
                s.id_rs2       = 5'($urandom_range(0, 7));
                s.id_rd        = 5'($urandom_range(0, 7));
                s.id_regwrite  = ($urandom_range(0, 4) != 0);
                s.id_ready     = 3'($urandom_range(0, depth(m) - 1));
                s.ex_rs1       = 5'($urandom_range(0, 7));
                s.ex_rs2       = 5'($urandom_range(0, 7));
                s.branch_taken = st[m].mem_stall ? st[m].branch_taken
                                                 : ($urandom_range(0, 9) == 0);
                s.mem_stall    = ($urandom_range(0, 5) == 0);
                st[m] = s;
            end
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst   = 1'b0;
        st[A] = idle();
        st[B] = idle();
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding unit for the in-order RV32I pipeline. It sits between ID and EX. It keeps a shadow pipeline of in-flight destination tags with per-instruction result-ready stages, and generates:
- the ID stall,
- the multi-cycle branch flush,
- per-operand forwarding selects for the EX instruction.

Unlike the two-stage combinational hazard/forward pair it replaces, it supports a configurable pipeline depth, variable result latency (ALU vs. load vs. multi-cycle), external freeze, and saturating performance counters.

## Interface
Parameters:
- DEPTH, 3: tracked stages after ID (stage 0 = EX … stage DEPTH-1 = WB); legal range 2–8.
- REG_W, 5: register address width.
- FLUSH_LEN, 1: cycles `flush` stays high per taken branch; legal range 1–4.
- PERF_W, 32: performance counter width.
- SEL_W = $clog2(DEPTH): width of each forwarding select (derived, not overridable).

Ports (clock and reset first):
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  REG_W  ID source registers; x0 never hazards.
- id_rd  in  REG_W  ID destination.
- id_regwrite  in  1  ID instruction writes `id_rd`.
- id_ready_stage  in  SEL_W  stage index at whose end the result exists (ALU 0, load 1).
- ex_rs1, ex_rs2  in  REG_W  sources of the instruction currently in EX.
- branch_taken  in  1  EX-stage branch/jump redirects; held stable while `mem_stall`.
- mem_stall  in  1  global freeze (memory wait).
- stall  out  1  hold PC and IF/ID, insert a bubble into EX.
- flush  out  1  squash IF/ID.
- fwd_sel_a, fwd_sel_b  out  SEL_W  EX operand source: 0 = register file, k = result of stage k (1…DEPTH-1).
- stall_cycles, flush_cycles  out  PERF_W  saturating event counters.

## Operation
- State:
  - DEPTH entries {valid, rd, regwrite, ready_stage}.
  - flush_cnt, counting 0…FLUSH_LEN-1.
  - Two perf counters.
- A stage k entry is a producer when valid && regwrite && rd != 0.
- Forwarding:
  - For each EX operand, take the smallest k in 1…DEPTH-1 whose producer rd matches the operand.
  - Select k only if ready_stage ≤ k-1; otherwise select 0.
  - Youngest producer always wins.
- Stall:
  - For each ID source, take the youngest matching producer j in 0…DEPTH-2.
  - stall = id_valid && that producer exists with ready_stage > j.
  - The stage DEPTH-1 producer is never checked, because the register file is write-first.
- Flush:
  - flush = branch_taken || flush_cnt != 0.
  - Flush has priority: when flush is high, stall is forced to 0.
- Shadow pipe advance, on each clock with !mem_stall:
  - entry[k] ← entry[k-1].
  - entry[0] ← ID info if id_valid && !stall && !flush; otherwise a bubble (valid = 0).
- flush_cnt:
  - Loads FLUSH_LEN-1 when branch_taken && flush_cnt == 0 && !mem_stall.
  - Decrements when nonzero && !mem_stall.
  - A branch_taken arriving while flush_cnt != 0 is ignored, because the instruction is on the wrong path.
- mem_stall high:
  - All state holds.
  - stall and flush are forced to 0.
  - fwd_sel_* remain valid for the held EX instruction.
- Perf counters (when !mem_stall):
  - stall_cycles increments on each stall cycle.
  - flush_cycles increments on each flush cycle.
  - Both saturate at all-ones.

## Timing
- Reset: all entries invalid, flush_cnt = 0, counters = 0. While rst is high: stall = 0, flush = 0, fwd_sel_a/b = 0.
- rst mid-flush or mid-stall: all outputs are 0 in the cycle after rst deasserts, unless new inputs create a hazard.
- stall, flush and fwd_sel_* are combinational from the current state and inputs (zero latency).
- State update latency is one cycle.
- Load-use with the defaults gives exactly one stall cycle. The consumer then forwards from stage 2.
- A producer with ready_stage = r stalls a dependent that immediately follows it for r cycles.
- A taken branch gives exactly FLUSH_LEN flush cycles, with no freeze in between. Each mem_stall cycle extends the window by one.
- Simultaneous branch_taken and a stall condition: flush = 1, stall = 0, entry[0] gets a bubble.

## Structure
- Package hazard_pkg:
  - shadow-entry struct type;
  - FWD_RF = 0 constant;
  - stage index constants EX = 0, MEM = 1;
  - function clog2_min1.
- Sub-module hazard_match: one instance per source operand. Inputs are the entry vector and the source register; outputs are the youngest matching index and hit/ready flags. It is shared by the forwarding and stall logic.
- Top level: shadow pipe registers, flush counter, perf counters, output muxing.

## Test plan
- ALU chain: add x5 (ready 0) → next cycle sub x7,x5,x1 → stall = 0; when the sub is in EX, fwd_sel_a = 1.
- Load-use: lw x6 (ready 1) → next cycle add x8,x2,x6 → stall = 1 for one cycle, stall_cycles = 1; the add reaches EX with fwd_sel_b = 2.
- x0 and aliasing: producer rd = x0 → no stall, fwd = 0. Two producers to x9 at stages 1 and 2 → fwd_sel_a = 1.
- Flush: FLUSH_LEN = 2, branch_taken in the same cycle as a load-use hazard → flush = 1 for 2 cycles, stall = 0, entry[0] is a bubble, flush_cycles = 2.
- Freeze and reset: mem_stall for 3 cycles during a load-use → state held, stall = 0 throughout, then one stall after release. rst asserted mid-flush → flush = 0 and counters = 0 the next cycle.
- Depth sweep: DEPTH = 5 with ready 3 → a dependent that immediately follows stalls 3 cycles, then forwards with fwd_sel = 4.
